edge_det_bank: RTL and testbench
================================

# edge_det_bank

Multi-channel, parametrised edge detector for the UART Rx front end and neighbouring blocks. Each channel synchronises an asynchronous input, optionally rejects glitches shorter than a programmable number of clocks, and emits single-cycle rise, fall and any-edge pulses gated by a per-channel run-time mode. A warm-up phase after reset loads the initial line level without emitting a pulse.

## Interface
- CH, 1: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- FILT_LEN, 3: consecutive cycles a new level must persist before acceptance (≥1); ignored when the filter is compiled out
- RST_LEVEL, 1'b1: reset value of synchroniser flops and level_o (UART idle = 1)

- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- din  in  CH  asynchronous line inputs
- mode  in  2*CH  per channel {mode[2i+1:2i]}: 00 off, 01 rise only, 10 fall only, 11 both
- ready_o  out  1  warm-up complete, pulses enabled
- level_o  out  CH  filtered, synchronised level
- rise_o  out  CH  one-cycle pulse, accepted 0→1, mode bit0 set
- fall_o  out  CH  one-cycle pulse, accepted 1→0, mode bit1 set
- edge_o  out  CH  rise_o | fall_o

## Operation
- Reset values: sync flops and level_o = RST_LEVEL (replicated); rise_o, fall_o, edge_o = 0; ready_o = 0; filter counters = 0; warm-up counter = 0.
- Global FSM: WARMUP → RUN. WARMUP lasts SYNC_STAGES clocks after arst_n deasserts; on the last WARMUP edge level_o <= synchroniser output s for every channel, counters cleared, no pulses, ready_o <= 1. RUN is permanent until reset.
- Per channel in RUN, with filter: cnt width $clog2(FILT_LEN+1), saturates at FILT_LEN−1.
  - s == level_o: cnt <= 0.
  - s != level_o and cnt < FILT_LEN−1: cnt <= cnt+1.
  - s != level_o and cnt == FILT_LEN−1: level_o <= s, cnt <= 0, pulse registered on the same edge.
- Any mismatch run broken before acceptance restarts the count from 0 (glitch of < FILT_LEN cycles is discarded entirely).
- Pulses: rise_o[i] <= accept & s & mode[2i]; fall_o[i] <= accept & ~s & mode[2i+1]; deasserted on the following edge unless another accept occurs (impossible in consecutive cycles when FILT_LEN ≥ 2).
- mode is sampled on the accept edge; changing mode never alters level_o or cnt, and mode 00 still tracks level.
- Channels are fully independent; simultaneous accepts on several channels all pulse in the same cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, and WARMUP re-runs after release.

## Timing
- din step stable before clock edge 0 (relative to sync capture): s changes after edge SYNC_STAGES−1; level_o and pulse change after edge SYNC_STAGES+FILT_LEN−1 (defaults: edge 4).
- Filter compiled out: equivalent to FILT_LEN = 1, latency SYNC_STAGES edges.
- All outputs registered; no combinational path from din or mode to outputs.
- Pulse width exactly 1 clock.

## Configuration
- EDGE_DET_FILTER_EN defined: counters and glitch rejection present as above.
- Not defined: no counters; in RUN, level_o <= s every cycle, pulse on any s != level_o; FILT_LEN is unused.

## Test plan
- Reset with din = 0, RST_LEVEL = 1: ready_o rises after 2 clocks, level_o = 0, no fall_o pulse during or after warm-up.
- CH = 1, mode = 11, din 1→0 held: fall_o and edge_o high for exactly 1 cycle, 4 edges after change; level_o = 0 on the same edge.
- Glitch: din low for 2 cycles then high (FILT_LEN = 3): no pulse, level_o stays 1; low for 3 cycles: fall_o pulse.
- CH = 4, mode = {11,10,01,00}, all din toggle 1→0→1 simultaneously: fall pulses on ch3, ch2 only; rise pulses on ch3, ch1 only; ch0 level_o tracks with no pulses.
- arst_n pulsed low while cnt = 2 on a pending change: outputs return to reset values, no pulse emitted, warm-up repeats.
- Filter compiled out, 1-cycle din glitch: level_o follows, one fall then one rise pulse in consecutive cycles, latency 2 edges.

Source files
------------

// File: rtl/edge_det_bank.sv
// rtl/edge_det_bank.sv - multi-channel synchronised edge detector with warm-up and optional glitch filter (EDGE_DET_FILTER_EN)
module edge_det_bank #(
  parameter int   CH          = 1,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_LEN    = 3,
  parameter logic RST_LEVEL   = 1'b1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic [CH-1:0]   din,
  input  logic [2*CH-1:0] mode,
  output logic            ready_o,
  output logic [CH-1:0]   level_o,
  output logic [CH-1:0]   rise_o,
  output logic [CH-1:0]   fall_o,
  output logic [CH-1:0]   edge_o
);

  // Elaboration-time guard against nonsensical parameter sets.
  if (CH < 1 || SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
    $error("edge_det_bank: illegal parameter combination");
  end

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam int WW = $clog2(SYNC_STAGES + 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(SYNC_STAGES - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   warm_cnt;
  logic [WW-1:0]   warm_cnt_nxt;
  logic            warm_done;

  logic [SYNC_STAGES-1:0] sync_q [CH];
  logic [CH-1:0]          s;
  logic [CH-1:0]          s_settle;
  logic [CH-1:0]          accept;

  // Global state register; ready_o is registered so it rises with the level load.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state    <= WARMUP;
      warm_cnt <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
      ready_o  <= (state_nxt == RUN);
    end
  end

  // Warm-up sequencing: count SYNC_STAGES clocks, then enter RUN for good.
  always_comb begin
    state_nxt    = state;
    warm_cnt_nxt = warm_cnt;
    warm_done    = 1'b0;
    case (state)
      WARMUP: begin
        if (warm_cnt == WARM_LAST) begin
          warm_done    = 1'b1;
          state_nxt    = RUN;
          warm_cnt_nxt = '0;
        end else begin
          warm_cnt_nxt = warm_cnt + 1'b1;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = WARMUP;
    endcase
  end

  // Synchroniser chains, one per channel, shifting toward the MSB.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {SYNC_STAGES{RST_LEVEL}};
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], din[i]};
      end
    end
  end

  // s is the synchroniser output; s_settle is the value s takes on this edge,
  // used at the end of warm-up so level_o and s agree and no pulse follows.
  always_comb begin
    s        = '0;
    s_settle = '0;
    for (int i = 0; i < CH; i++) begin
      s[i]        = sync_q[i][SYNC_STAGES-1];
      s_settle[i] = sync_q[i][SYNC_STAGES-2];
    end
  end

`ifdef EDGE_DET_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [CW-1:0] cnt_q [CH];

  // A new level is accepted once it has differed for FILT_LEN consecutive clocks.
  always_comb begin
    accept = '0;
    for (int i = 0; i < CH; i++) begin
      accept[i] = (state == RUN) && (s[i] != level_o[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  // Persistence counters: any agreement with level_o restarts the run from zero.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (state != RUN || s[i] == level_o[i] || cnt_q[i] == CNT_LAST) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  // Without the filter every difference is accepted immediately.
  always_comb begin
    accept = '0;
    for (int i = 0; i < CH; i++) begin
      accept[i] = (state == RUN) && (s[i] != level_o[i]);
    end
  end
`endif

  // Level tracking and single-cycle pulses; mode only gates the pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      level_o <= {CH{RST_LEVEL}};
      rise_o  <= '0;
      fall_o  <= '0;
      edge_o  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        rise_o[i] <= accept[i] &  s[i] & mode[2*i];
        fall_o[i] <= accept[i] & ~s[i] & mode[2*i+1];
        edge_o[i] <= accept[i] & ((s[i] & mode[2*i]) | (~s[i] & mode[2*i+1]));
        if (warm_done) begin
          level_o[i] <= s_settle[i];
        end else if (accept[i]) begin
          level_o[i] <= s[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_det_bank.sv
// tb/tb_edge_det_bank.sv - directed self-checking bench for edge_det_bank
module tb_edge_det_bank;

`ifdef EDGE_DET_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       arst_n;
  logic [3:0] din;
  logic [7:0] mode;
  logic       ready_o;
  logic [3:0] level_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic [3:0] edge_o;

  int checks;
  int errors;

  edge_det_bank #(
    .CH          (4),
    .SYNC_STAGES (2),
    .FILT_LEN    (3),
    .RST_LEVEL   (1'b1)
  ) u_dut (
    .clk     (clk),
    .arst_n  (arst_n),
    .din     (din),
    .mode    (mode),
    .ready_o (ready_o),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .edge_o  (edge_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] lvl, input logic [3:0] r,
                            input logic [3:0] f);
    check({tag, "_lvl"},  32'(level_o), 32'(lvl));
    check({tag, "_rise"}, 32'(rise_o),  32'(r));
    check({tag, "_fall"}, 32'(fall_o),  32'(f));
    check({tag, "_edge"}, 32'(edge_o),  32'(r | f));
  endtask

  // Called with arst_n low; releases it and checks the warm-up sequence with din held.
  task automatic warmup_check(input string tag, input logic [3:0] lvl_final);
    arst_n = 1'b1;
    tick();
    check({tag, "_rdy0"}, 32'(ready_o), 32'd0);
    check_outs({tag, "_w0"}, 4'hF, 4'h0, 4'h0);
    tick();
    check({tag, "_rdy1"}, 32'(ready_o), 32'd1);
    check_outs({tag, "_w1"}, lvl_final, 4'h0, 4'h0);
    for (int t = 0; t < 6; t++) begin
      tick();
      check_outs($sformatf("%s_post%0d", tag, t), lvl_final, 4'h0, 4'h0);
    end
  endtask

  task automatic run_step(input string tag, input logic [3:0] d, input logic [3:0] lvl_old,
                          input logic [3:0] lvl_new, input logic [3:0] rise_exp,
                          input logic [3:0] fall_exp);
    din = d;
    for (int t = 1; t <= LAT + 2; t++) begin
      tick();
      check_outs($sformatf("%s_t%0d", tag, t), (t > LAT) ? lvl_new : lvl_old,
                 (t == LAT + 1) ? rise_exp : 4'h0, (t == LAT + 1) ? fall_exp : 4'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst_n = 1'b0;
    din    = 4'h0;
    mode   = 8'hFF;

    // Reset state, then warm-up with din low: level loads 0, no fall pulse.
    tick();
    check("rst_rdy", 32'(ready_o), 32'd0);
    check_outs("rst", 4'hF, 4'h0, 4'h0);
    tick();
    check_outs("rst2", 4'hF, 4'h0, 4'h0);
    warmup_check("wu", 4'h0);

    // All channels both-edge mode.
    run_step("rise_all", 4'hF, 4'h0, 4'hF, 4'hF, 4'h0);
    run_step("fall_all", 4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
    run_step("rise_all2", 4'hF, 4'h0, 4'hF, 4'hF, 4'h0);

    // Mixed modes ch3..ch0 = 11,10,01,00.
    mode = 8'b11_10_01_00;
    run_step("mode_fall", 4'h0, 4'hF, 4'h0, 4'h0, 4'b1100);
    run_step("mode_rise", 4'hF, 4'h0, 4'hF, 4'b1010, 4'h0);
    mode = 8'hFF;

`ifdef EDGE_DET_FILTER_EN
    // Two-cycle glitch is rejected completely.
    din = 4'h0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check_outs($sformatf("glitch2_t%0d", t), 4'hF, 4'h0, 4'h0);
      if (t == 2) din = 4'hF;
    end
    // Three-cycle low is accepted, then the return high is accepted too.
    din = 4'h0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check_outs($sformatf("glitch3_t%0d", t), (t >= 5 && t <= 7) ? 4'h0 : 4'hF,
                 (t == 8) ? 4'hF : 4'h0, (t == 5) ? 4'hF : 4'h0);
      if (t == 3) din = 4'hF;
    end
`else
    // One-cycle glitch passes through: fall then rise on consecutive cycles.
    din = 4'h0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      check_outs($sformatf("glitch1_t%0d", t), (t == 3) ? 4'h0 : 4'hF,
                 (t == 4) ? 4'hF : 4'h0, (t == 3) ? 4'hF : 4'h0);
      if (t == 1) din = 4'hF;
    end
`endif

    // Reset asserted one edge before a pending accept.
    din = 4'h0;
    for (int t = 1; t <= LAT; t++) begin
      tick();
      check_outs($sformatf("pend_t%0d", t), 4'hF, 4'h0, 4'h0);
    end
    arst_n = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(ready_o), 32'd0);
    check_outs("mid_rst", 4'hF, 4'h0, 4'h0);
    tick();
    check("mid_rst_rdy2", 32'(ready_o), 32'd0);
    check_outs("mid_rst2", 4'hF, 4'h0, 4'h0);
    warmup_check("rewu", 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
